// File: rtl/rob_id_pkg.sv
// Shared types and helpers for the ROB unique-ID allocator.
// A uid is {zero pad, row, col}; helpers build and split it.
package rob_id_pkg;

   localparam int DEF_ROW_W = 2;
   localparam int DEF_COL_W = 2;

   typedef struct packed {
      logic [DEF_ROW_W-1:0] row;
      logic [DEF_COL_W-1:0] col;
   } uid_t;

   function automatic int row_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int col_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [31:0] make_uid(
      input logic [31:0] row,
      input logic [31:0] col,
      input int          cw
   );
      return (row << cw) | col;
   endfunction

   function automatic void split_uid(
      input  logic [31:0] uid,
      input  int          cw,
      output logic [31:0] row,
      output logic [31:0] col
   );
      row = uid >> cw;
      col = uid & ((32'd1 << cw) - 32'd1);
   endfunction

endpackage

// File: rtl/rob_id_row.sv
// One ROB row: bind flag, orig-ID tag, tail pointer and column bitmap.
// Columns are issued strictly in order from the tail pointer.
module rob_id_row
   import rob_id_pkg::*;
#(
   parameter int ID_WIDTH = 4,
   parameter int NUM_COLS = 4,
   localparam int COL_W = col_w(NUM_COLS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                grant,
   input  logic [ID_WIDTH-1:0] grant_tag,
   input  logic                free,
   input  logic [COL_W-1:0]    free_col,
   output logic                bound,
   output logic [ID_WIDTH-1:0] tag,
   output logic [COL_W-1:0]    tail,
   output logic [NUM_COLS-1:0] valid
);

   logic last_free;

   // The freed bit is the only one set: the row empties unless a grant refills it.
   assign last_free = free && (valid == (NUM_COLS'(1) << free_col));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bound <= 1'b0;
         tag   <= '0;
         tail  <= '0;
         valid <= '0;
      end else begin
         if (grant) begin
            valid[tail] <= 1'b1;
            tail        <= tail + 1'b1;
            if (!bound) begin
               bound <= 1'b1;
               tag   <= grant_tag;
            end
         end
         if (free)
            valid[free_col] <= 1'b0;
         if (last_free && !grant) begin
            bound <= 1'b0;
            tail  <= '0;
         end
      end
   end

endmodule

// File: rtl/rob_id_allocator.sv
// Maps orig IDs onto {row,col} ROB uids with in-order columns per ID.
// Top level: row select, free decode, occupancy and free response.
module rob_id_allocator
   import rob_id_pkg::*;
#(
   parameter int ID_WIDTH = 4,
   parameter int NUM_ROWS = 4,
   parameter int NUM_COLS = 4,
   localparam int ROW_W = row_w(NUM_ROWS),
   localparam int COL_W = col_w(NUM_COLS),
   localparam int OCC_W = $clog2(NUM_ROWS * NUM_COLS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alloc_valid,
   input  logic [ID_WIDTH-1:0] alloc_orig_id,
   output logic                alloc_ready,
   output logic [ID_WIDTH-1:0] alloc_uid,
   input  logic                free_valid,
   input  logic [ID_WIDTH-1:0] free_uid,
   output logic                rsp_valid,
   output logic [ID_WIDTH-1:0] rsp_orig_id,
   output logic                rsp_err,
   output logic [OCC_W-1:0]    occupancy,
   output logic                full,
   output logic                empty
);

   logic [NUM_ROWS-1:0] row_bound;
   logic [ID_WIDTH-1:0] row_tag   [NUM_ROWS];
   logic [COL_W-1:0]    row_tail  [NUM_ROWS];
   logic [NUM_COLS-1:0] row_valid [NUM_ROWS];

   logic             sel_found;
   logic [ROW_W-1:0] sel_row;
   logic [COL_W-1:0] sel_tail;
   logic             grant;

   logic [ROW_W-1:0] free_row;
   logic [COL_W-1:0] free_col;
   logic             pad_ok;
   logic             free_ok;

   // A hit on a bound row wins over any unbound row, so IDs never split.
   always_comb begin
      sel_found = 1'b0;
      sel_row   = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (!sel_found && row_bound[r] &&
             row_tag[r] == alloc_orig_id) begin
            sel_found = 1'b1;
            sel_row   = ROW_W'(r);
         end
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (!sel_found && !row_bound[r]) begin
            sel_found = 1'b1;
            sel_row   = ROW_W'(r);
         end
      end
   end

   assign sel_tail    = row_tail[sel_row];
   assign alloc_ready = sel_found && !row_valid[sel_row][sel_tail];
   assign grant       = alloc_valid && alloc_ready;
   assign alloc_uid   = ID_WIDTH'(make_uid(32'(sel_row),
                                           32'(sel_tail), COL_W));

   assign free_row = free_uid[COL_W +: ROW_W];
   assign free_col = free_uid[COL_W-1:0];
   assign pad_ok   = (free_uid >> (ROW_W + COL_W)) == '0;
   assign free_ok  = free_valid && pad_ok &&
                     row_valid[free_row][free_col];

   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      rob_id_row #(
         .ID_WIDTH (ID_WIDTH),
         .NUM_COLS (NUM_COLS)
      ) u_row (
         .clk       (clk),
         .rst       (rst),
         .grant     (grant && sel_row == ROW_W'(r)),
         .grant_tag (alloc_orig_id),
         .free      (free_ok && free_row == ROW_W'(r)),
         .free_col  (free_col),
         .bound     (row_bound[r]),
         .tag       (row_tag[r]),
         .tail      (row_tail[r]),
         .valid     (row_valid[r])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_orig_id <= '0;
         occupancy   <= '0;
      end else begin
         rsp_valid   <= free_valid;
         rsp_err     <= free_valid && !free_ok;
         rsp_orig_id <= free_ok ? row_tag[free_row] : '0;
         unique case (1'b1)
            grant && !free_ok: occupancy <= occupancy + 1'b1;
            free_ok && !grant: occupancy <= occupancy - 1'b1;
            default:           occupancy <= occupancy;
         endcase
      end
   end

   assign full  = occupancy == OCC_W'(NUM_ROWS * NUM_COLS);
   assign empty = occupancy == '0;

endmodule
